// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch stage.
//   PC_STEP_DEFAULT   sequential fetch increment in bytes
//   RESET_PC_DEFAULT  PC loaded while reset is asserted
//   fetch_entry_t     one prefetch FIFO entry (PC plus instruction word) at the
//                     default 32-bit address/data widths
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int unsigned PC_STEP_DEFAULT      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
  localparam int          FETCH_ADDR_W_DEFAULT = 32;
  localparam int          FETCH_DATA_W_DEFAULT = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W_DEFAULT-1:0] pc;
    logic [FETCH_DATA_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// ---------------------------------------------------------------------------
// if_sync_fifo
// Single-clock FIFO holding prefetched instruction entries. The head entry is
// read straight out of the storage array, so a word pushed on one edge is
// visible at the head in the following cycle.
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset, empties the FIFO
//   push   in   write wdata (accepted when not full, or when popping too)
//   pop    in   drop the head entry (ignored when empty)
//   flush  in   discard every entry; wins over push and pop
//   wdata  in   entry to write
//   rdata  out  head entry (undefined content while empty)
//   count  out  number of stored entries
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module if_sync_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage: sequences the fetch PC, issues requests to an
// in-order variable-latency instruction memory, buffers returned words with
// their PC in a prefetch FIFO and hands them to decode.
//   clk            in   clock, rising edge
//   rst_n          in   synchronous active-low reset
//   i_redirect     in   taken jump/branch: flush and refetch from i_redirect_pc
//   i_redirect_pc  in   redirect target (low two bits ignored)
//   o_imem_req     out  fetch request valid
//   o_imem_addr    out  fetch byte address (word aligned)
//   i_imem_gnt     in   request accepted this cycle
//   i_imem_rvalid  in   response valid, in request order
//   i_imem_rdata   in   response instruction word
//   o_valid        out  instruction available to decode
//   o_instruction  out  head instruction (0 while empty)
//   o_pc           out  PC of head instruction
//   i_ready        in   decode takes the head this cycle
// Optional (macro IF_PERF_COUNTERS_EN):
//   o_fetch_cnt    out  saturating count of instructions handed to decode
//   o_bubble_cnt   out  saturating count of cycles decode was starved
// ---------------------------------------------------------------------------
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instruction,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_ready
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_bubble_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Outstanding requests can exceed FIFO_DEPTH after redirects, since words
  // still in flight to be dropped do not consume credits. Extra headroom bits
  // cover a run of back-to-back redirects against a slow memory.
  localparam int OUT_W = CNT_W + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RESET_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  outstanding_nxt;
  logic [OUT_W-1:0]  drop_cnt;
  logic [OUT_W:0]    credit_used;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              req_fire;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;

  assign redirect_target = {i_redirect_pc[ADDR_W-1:2], 2'b00};

  // Credits: every buffered word plus every in-flight word that will be kept
  // must fit in the FIFO, so a response can always be accepted.
  assign credit_used = (OUT_W+1)'(fifo_count) + {1'b0, outstanding} - {1'b0, drop_cnt};
  assign o_imem_req  = rst_n && !i_redirect && !fifo_full &&
                       (credit_used < (OUT_W+1)'(FIFO_DEPTH));
  assign o_imem_addr = fetch_pc;

  assign req_fire = o_imem_req && i_imem_gnt;
  // Responses during a redirect or while stale words are pending never land.
  assign push     = i_imem_rvalid && !i_redirect && (drop_cnt == '0);
  // A pop coinciding with a redirect is discarded along with the flush.
  assign pop      = o_valid && i_ready && !i_redirect;

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = i_imem_rdata;

  assign o_valid       = !fifo_empty;
  assign o_instruction = fifo_empty ? '0 : head_entry.instr;
  assign o_pc          = fifo_empty ? resp_pc : head_entry.pc;

  // In-flight request count after this cycle's grant and response.
  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire) begin
      outstanding_nxt = outstanding_nxt + OUT_W'(1);
    end
    if (i_imem_rvalid) begin
      outstanding_nxt = outstanding_nxt - OUT_W'(1);
    end
  end

  // PC sequencing and drop bookkeeping. On a redirect every request still in
  // flight (after this cycle's response) becomes a word to discard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_AL;
      resp_pc     <= RESET_AL;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_redirect) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (i_imem_rvalid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - OUT_W'(1);
          end else begin
            resp_pc <= resp_pc + STEP;
          end
        end
      end
    end
  end

  if_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef IF_PERF_COUNTERS_EN
  // Saturating counters of delivered instructions and starved decode cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_fetch_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (pop && (o_fetch_cnt != '1)) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (i_ready && !o_valid && (o_bubble_cnt != '1)) begin
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
// Directed bench for if_prefetch_stage. A second instance with a wrapping
// reset PC runs alongside the main one, fed by its own 1-cycle memory.
// Perf-counter checks are compiled in when IF_PERF_COUNTERS_EN is defined.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] w_fetch_cnt;
  logic [31:0] w_bubble_cnt;
`endif

  // Memory model state and per-cycle samples
  pend_t       pend[$];
  logic [31:0] w_pcs[$];
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic        w_fire_prev = 1'b0;
  logic [31:0] w_addr_prev = '0;
  logic        w_fire;
  logic [31:0] w_addr_q;
  logic        s_req, s_fire, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  int checks = 0;
  int failures = 0;

  if_prefetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_valid       (valid),
    .o_instruction (instr),
    .o_pc          (pc),
    .i_ready       (ready)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_bubble_cnt  (bubble_cnt)
`endif
  );

  if_prefetch_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_w (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (1'b0),
    .i_redirect_pc (32'h0),
    .o_imem_req    (w_req),
    .o_imem_addr   (w_addr),
    .i_imem_gnt    (1'b1),
    .i_imem_rvalid (w_rvalid),
    .i_imem_rdata  (w_rdata),
    .o_valid       (w_valid),
    .o_instruction (w_instr),
    .o_pc          (w_pc),
    .i_ready       (1'b1)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .o_fetch_cnt   (w_fetch_cnt),
    .o_bubble_cnt  (w_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive memory responses, sample outputs after settling,
  // then update the memory models at the rising edge.
  task automatic applyStimulus();
    rvalid = 1'b0;
    rdata  = '0;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = instr_of(pend[0].addr);
    end
    gnt      = gnt_en;
    w_rvalid = rst_n && w_fire_prev;
    w_rdata  = instr_of(w_addr_prev);
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_fire   = imem_req && gnt;
    s_valid  = valid;
    s_pc     = pc;
    s_instr  = instr;
    w_fire   = w_req;
    w_addr_q = w_addr;
    if (w_valid === 1'b1) w_pcs.push_back(w_pc);
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      w_fire_prev = 1'b0;
    end else begin
      if (rvalid) void'(pend.pop_front());
      if (s_fire) pend.push_back('{addr: s_addr, due: cyc + lat});
      w_fire_prev = w_fire;
      w_addr_prev = w_addr_q;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic doReset(input logic rdy);
    rst_n    = 1'b0;
    redirect = 1'b0;
    ready    = rdy;
    repeat (3) applyStimulus();
    w_pcs.delete();
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (s_valid !== 1'b1 && n < 30);
    checkOutput(tag, s_valid, 1);
  endtask

  initial begin
    int   grants;
    logic found;
    redirect_pc = '0;
    gnt_en      = 1'b1;

    // Reset state
    lat = 1;
    doReset(1'b1);
    checkOutput("rst_valid", s_valid, 0);
    checkOutput("rst_req", s_req, 0);
    checkOutput("rst_pc", s_pc, 0);
    checkOutput("rst_instr", s_instr, 0);
    checkOutput("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);

    // Test 1: sequential stream, 1-cycle memory, decode always ready
    $display("[TB] test 1: sequential fetch");
    applyStimulus();
    checkOutput("t1_req_c0", s_req, 1);
    checkOutput("t1_addr_c0", s_addr, 0);
    checkOutput("t1_valid_c0", s_valid, 0);
    applyStimulus();
    checkOutput("t1_valid_c1", s_valid, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("t1_valid", s_valid, 1);
      checkOutput("t1_pc", s_pc, 32'(4 * k));
      checkOutput("t1_instr", s_instr, instr_of(32'(4 * k)));
    end

    // Test 5a: wrapping reset PC on the second instance
    checkOutput("t5_wrap_count_ok", (w_pcs.size() >= 3), 1);
    if (w_pcs.size() >= 3) begin
      checkOutput("t5_wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
      checkOutput("t5_wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
      checkOutput("t5_wrap_pc2", w_pcs[2], 32'h0000_0000);
    end

    // Test 2: decode stalled, credits stop requests at FIFO depth
    $display("[TB] test 2: backpressure");
    gnt_en = 1'b0;
    doReset(1'b0);
    applyStimulus();
    checkOutput("t2_hold_req0", s_req, 1);
    checkOutput("t2_hold_addr0", s_addr, 0);
    applyStimulus();
    checkOutput("t2_hold_req1", s_req, 1);
    checkOutput("t2_hold_addr1", s_addr, 0);
    gnt_en = 1'b1;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      if (s_fire) grants++;
    end
    checkOutput("t2_grants", grants, 4);
    checkOutput("t2_req_stopped", s_req, 0);
    checkOutput("t2_head_pc", s_pc, 0);
    ready = 1'b1;
    applyStimulus();
    checkOutput("t2_pop_pc0", s_pc, 0);
    checkOutput("t2_req_still_off", s_req, 0);
    applyStimulus();
    checkOutput("t2_pop_pc4", s_pc, 4);
    checkOutput("t2_req_resume", s_req, 1);
    checkOutput("t2_req_resume_addr", s_addr, 16);
    applyStimulus();
    checkOutput("t2_pop_pc8", s_pc, 8);
    applyStimulus();
    checkOutput("t2_pop_pc12", s_pc, 12);
    applyStimulus();
    checkOutput("t2_pop_pc16", s_pc, 16);
    checkOutput("t2_pop_valid16", s_valid, 1);

    // Test 3: 3-cycle memory, redirect with three requests in flight
    $display("[TB] test 3: redirect with outstanding requests");
    lat = 3;
    doReset(1'b1);
    repeat (3) applyStimulus();
    checkOutput("t3_valid_before", s_valid, 0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("t3_req_in_redirect", s_req, 0);
    applyStimulus();
    checkOutput("t3_addr_after", s_addr, 32'h100);
    checkOutput("t3_req_after", s_req, 1);
    checkOutput("t3_valid_after", s_valid, 0);
    waitValid("t3_first_valid");
    checkOutput("t3_first_pc", s_pc, 32'h100);
    checkOutput("t3_first_instr", s_instr, instr_of(32'h100));
    applyStimulus();
    checkOutput("t3_second_pc", s_pc, 32'h104);

    // Test 4a: unaligned redirect target
    $display("[TB] test 4: aligned redirect, coincident events");
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    applyStimulus();
    redirect = 1'b0;
    applyStimulus();
    checkOutput("t4_addr_aligned", s_addr, 32'h200);
    checkOutput("t4_valid_flushed", s_valid, 0);
    waitValid("t4_first_valid");
    checkOutput("t4_first_pc", s_pc, 32'h200);
    checkOutput("t4_first_instr", s_instr, instr_of(32'h200));

    // Test 4b: redirect in a cycle that both pops and receives a response
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (valid === 1'b1 && pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("t4_coincident_setup", found, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    applyStimulus();
    redirect = 1'b0;
    applyStimulus();
    checkOutput("t4_valid_after_redirect", s_valid, 0);
    waitValid("t4_coinc_valid");
    checkOutput("t4_coinc_pc", s_pc, 32'h300);
    applyStimulus();
    checkOutput("t4_coinc_pc_next", s_pc, 32'h304);

    // Back-to-back redirects
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    applyStimulus();
    redirect_pc = 32'h500;
    applyStimulus();
    redirect = 1'b0;
    waitValid("t4_b2b_valid");
    checkOutput("t4_b2b_pc", s_pc, 32'h500);
    applyStimulus();
    checkOutput("t4_b2b_pc_next", s_pc, 32'h504);

    // Test 5b: reset in the middle of a stream
    $display("[TB] test 5: mid-stream reset");
    rst_n = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_rst_valid", s_valid, 0);
    checkOutput("t5_rst_pc", s_pc, 0);
    checkOutput("t5_rst_req", s_req, 0);
    checkOutput("t5_rst_wrap_valid", w_valid, 0);
    checkOutput("t5_rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
    rst_n = 1'b1;

`ifdef IF_PERF_COUNTERS_EN
    // Test 6: 10 delivered instructions and 3 starved cycles
    $display("[TB] test 6: performance counters");
    lat = 1;
    doReset(1'b1);
    checkOutput("t6_fetch_rst", fetch_cnt, 0);
    checkOutput("t6_bubble_rst", bubble_cnt, 0);
    repeat (12) applyStimulus();
    ready       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    applyStimulus();
    redirect = 1'b0;
    ready    = 1'b1;
    applyStimulus();
    ready = 1'b0;
    applyStimulus();
    checkOutput("t6_fetch_cnt", fetch_cnt, 10);
    checkOutput("t6_bubble_cnt", bubble_cnt, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
